local_div: RTL

Iterative radix-2 restoring divider, the inverse companion of the local multiplier in the TPU datapath.
- Accepts a numerator/denominator pair on a start strobe.
- Produces one quotient bit per enabled clock.
- Returns quotient and remainder with a one-cycle done pulse.
- Sits beside the multiplier in the vector lane ALU; the lane control FSM drives start and waits on done.

---
 rtl/local_div.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/local_div.sv
// local_div: iterative radix-2 restoring divider, one quotient bit per enabled clock.
// Signed mode divides magnitudes and fixes signs in a final cycle. The quotient
// truncates toward zero and the remainder takes the sign of the numerator.
module local_div #(
    parameter int    LPA_WIDTHN         = 32,
    parameter int    LPA_WIDTHD         = 32,
    parameter string LPA_REPRESENTATION = "SIGNED"
) (
    input  logic                  clock,
    input  logic                  aclr,
    input  logic                  clken,
    input  logic                  start,
    input  logic [LPA_WIDTHN-1:0] numer,
    input  logic [LPA_WIDTHD-1:0] denom,
    output logic [LPA_WIDTHN-1:0] quotient,
    output logic [LPA_WIDTHD-1:0] remain,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero
);

    localparam int unsigned WN        = LPA_WIDTHN;
    localparam int unsigned WD        = LPA_WIDTHD;
    localparam int unsigned CNT_W     = (WN > 1) ? $clog2(WN) : 1;
    localparam bit          IS_SIGNED = (LPA_REPRESENTATION == "SIGNED");

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WN-1:0]      num_q, num_d;       // numerator bits shift out the top, quotient bits shift in the bottom
    logic [WD-1:0]      den_q, den_d;       // denominator magnitude
    logic [WD-1:0]      pr_q, pr_d;         // partial remainder
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic [WN-1:0]      quot_q, quot_d;
    logic [WD-1:0]      rem_q, rem_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;

    logic               numer_neg;
    logic               denom_neg;
    logic [WN-1:0]      numer_mag;
    logic [WD-1:0]      denom_mag;
    logic [WD:0]        pr_shift;
    logic [WD:0]        pr_sub;
    logic               trial_ok;

    // Operand magnitudes and the one-bit trial-subtract step
    always_comb begin
        numer_neg = IS_SIGNED && numer[WN-1];
        denom_neg = IS_SIGNED && denom[WD-1];
        numer_mag = numer_neg ? (~numer + WN'(1)) : numer;
        denom_mag = denom_neg ? (~denom + WD'(1)) : denom;
        pr_shift  = {pr_q, num_q[WN-1]};
        pr_sub    = pr_shift - {1'b0, den_q};
        trial_ok  = (pr_shift >= {1'b0, den_q});
    end

    // Next-state and next-output logic; nothing changes while clken is low
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        den_d   = den_q;
        pr_d    = pr_q;
        cnt_d   = cnt_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        done_d  = done_q;
        dz_d    = dz_q;

        if (clken) begin
            done_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        num_d   = numer_mag;
                        den_d   = denom_mag;
                        pr_d    = '0;
                        cnt_d   = CNT_W'(WN - 1);
                        q_neg_d = numer_neg ^ denom_neg;
                        r_neg_d = numer_neg;
                        busy_d  = 1'b1;
                        state_d = CALC;
                    end
                end
                CALC: begin
                    pr_d  = trial_ok ? WD'(pr_sub) : WD'(pr_shift);
                    num_d = {num_q[WN-2:0], trial_ok};
                    if (cnt_q == '0) begin
                        state_d = FIX;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                FIX: begin
                    // A zero divisor yields all-ones quotient; the remainder path
                    // then reproduces the low numerator bits on its own.
                    if (den_q == '0) begin
                        quot_d = '1;
                    end else begin
                        quot_d = q_neg_q ? (~num_q + WN'(1)) : num_q;
                    end
                    rem_d   = r_neg_q ? (~pr_q + WD'(1)) : pr_q;
                    dz_d    = (den_q == '0);
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            state_q <= IDLE;
            num_q   <= '0;
            den_q   <= '0;
            pr_q    <= '0;
            cnt_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            den_q   <= den_d;
            pr_q    <= pr_d;
            cnt_q   <= cnt_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign quotient    = quot_q;
    assign remain      = rem_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dz_q;

endmodule
